// File: rtl/mux2_8_arb.sv
// mux2_8_arb: packet-level round-robin arbiter in front of the shared
// 8-bit 2:1 datapath mux, with a single-entry registered output stage.

module mux2_8 #(
   parameter int WIDTH = 8
) (
   input  logic             sel,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);

   assign y = sel ? b : a;

endmodule

module mux2_8_arb #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_data,
   input  logic             req0_last,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_data,
   input  logic             req1_last,
   output logic             req1_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last,
   output logic             out_src,
   input  logic             out_ready
);

   typedef enum logic [1:0] {
      IDLE,
      GRANT0,
      GRANT1
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic             prio;
   logic             sel;
   logic             acc;
   logic             acc_last;
   logic             slot_free;
   logic [WIDTH-1:0] mux_data;

   // Output slot can take a beat when empty or draining this cycle.
   assign slot_free = !out_valid || out_ready;

   mux2_8 #(
      .WIDTH (WIDTH)
   ) u_mux (
      .sel (sel),
      .a   (req0_data),
      .b   (req1_data),
      .y   (mux_data)
   );

   // Grant FSM next state, mux select and per-requester ready.
   always_comb begin
      state_nx   = state;
      sel        = 1'b0;
      acc        = 1'b0;
      acc_last   = 1'b0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      unique case (state)
         IDLE: begin
            if (req0_valid && req1_valid)
               state_nx = prio ? GRANT0 : GRANT1;
            else if (req0_valid)
               state_nx = GRANT0;
            else if (req1_valid)
               state_nx = GRANT1;
         end
         GRANT0: begin
            sel        = 1'b0;
            req0_ready = slot_free;
            acc        = req0_valid && slot_free;
            acc_last   = req0_last;
            if (acc && req0_last)
               state_nx = IDLE;
         end
         GRANT1: begin
            sel        = 1'b1;
            req1_ready = slot_free;
            acc        = req1_valid && slot_free;
            acc_last   = req1_last;
            if (acc && req1_last)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // State, priority and output register update.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         prio      <= 1'b1;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_src   <= 1'b0;
      end else begin
         state <= state_nx;
         if (acc) begin
            out_valid <= 1'b1;
            out_data  <= mux_data;
            out_last  <= acc_last;
            out_src   <= sel;
            if (acc_last)
               prio <= sel;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mux2_8_arb.sv
// tb_mux2_8_arb: directed stimulus with a queue scoreboard and an
// independent output monitor for mux2_8_arb.

module tb_mux2_8_arb;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
      logic [3:0] gap;
   } beat_t;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
      logic       src;
   } exp_t;

   logic       clk;
   logic       reset;
   logic       rv [2];
   logic [7:0] rd [2];
   logic       rl [2];
   logic [1:0] rr;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_last;
   logic       out_src;
   logic       out_ready;

   beat_t q [2][$];
   exp_t  sb [$];
   int    checks;
   int    errors;

   mux2_8_arb #(
      .WIDTH (8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req0_valid (rv[0]),
      .req0_data  (rd[0]),
      .req0_last  (rl[0]),
      .req0_ready (rr[0]),
      .req1_valid (rv[1]),
      .req1_data  (rd[1]),
      .req1_last  (rl[1]),
      .req1_ready (rr[1]),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_last   (out_last),
      .out_src    (out_src),
      .out_ready  (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic push(input int k, input logic [7:0] d,
                       input logic l, input logic [3:0] g);
      beat_t b;
      b.data = d;
      b.last = l;
      b.gap  = g;
      q[k].push_back(b);
   endtask

   task automatic expect_beat(input logic [7:0] d, input logic l,
                              input logic s);
      exp_t e;
      e.data = d;
      e.last = l;
      e.src  = s;
      sb.push_back(e);
   endtask

   task automatic drive(input int k);
      beat_t b;
      bit    done;
      forever begin
         if (q[k].size() == 0) begin
            rv[k] = 1'b0;
            @(posedge clk);
            #1;
         end else begin
            b = q[k].pop_front();
            rv[k] = 1'b0;
            repeat (int'(b.gap)) begin
               @(posedge clk);
               #1;
            end
            rv[k] = 1'b1;
            rd[k] = b.data;
            rl[k] = b.last;
            done  = 1'b0;
            while (!done) begin
               @(negedge clk);
               if (reset) begin
                  q[k].delete();
                  done = 1'b1;
               end else if (rr[k]) begin
                  done = 1'b1;
               end
               @(posedge clk);
               #1;
            end
            rv[k] = 1'b0;
         end
      end
   endtask

   // Monitor: every completed output handshake must match the scoreboard head.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: got data %0h src %0d",
                        out_data, out_src);
            end else begin
               e = sb.pop_front();
               chk("beat_data", {24'd0, out_data}, {24'd0, e.data});
               chk("beat_last", {31'd0, out_last}, {31'd0, e.last});
               chk("beat_src", {31'd0, out_src}, {31'd0, e.src});
            end
         end
      end
   end

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic wait_drain(input string nm);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got %0d pending expected 0", nm,
                  sb.size());
         sb.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      checks    = 0;
      errors    = 0;
      reset     = 1'b1;
      out_ready = 1'b1;
      rv[0] = 1'b0; rv[1] = 1'b0;
      rd[0] = 8'h00; rd[1] = 8'h00;
      rl[0] = 1'b0; rl[1] = 1'b0;
      fork
         drive(0);
         drive(1);
      join_none
      do_reset();

      // Reset state
      @(negedge clk);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data", {24'd0, out_data}, 32'd0);
      chk("rst_out_last", {31'd0, out_last}, 32'd0);
      chk("rst_out_src", {31'd0, out_src}, 32'd0);
      chk("rst_readies", {30'd0, rr}, 32'd0);

      // Single requester, 3-beat packet, latency and throughput
      push(0, 8'hA1, 1'b0, 4'd0);
      push(0, 8'hA2, 1'b0, 4'd0);
      push(0, 8'hA3, 1'b1, 4'd0);
      expect_beat(8'hA1, 1'b0, 1'b0);
      expect_beat(8'hA2, 1'b0, 1'b0);
      expect_beat(8'hA3, 1'b1, 1'b0);
      @(negedge clk);
      chk("t1_idle_ready", {30'd0, rr}, 32'd0);
      chk("t1_n_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      chk("t1_n1_ready0", {31'd0, rr[0]}, 32'd1);
      chk("t1_n1_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      chk("t1_n2_valid", {31'd0, out_valid}, 32'd1);
      chk("t1_n2_data", {24'd0, out_data}, 32'hA1);
      @(negedge clk);
      chk("t1_n3_data", {24'd0, out_data}, 32'hA2);
      @(negedge clk);
      chk("t1_n4_data", {24'd0, out_data}, 32'hA3);
      chk("t1_n4_last", {31'd0, out_last}, 32'd1);
      @(negedge clk);
      chk("t1_n5_valid", {31'd0, out_valid}, 32'd0);
      wait_drain("t1");

      // Tie after reset: alternating one-beat packets
      do_reset();
      @(negedge clk);
      push(0, 8'h11, 1'b1, 4'd0);
      push(0, 8'h11, 1'b1, 4'd0);
      push(1, 8'h22, 1'b1, 4'd0);
      push(1, 8'h22, 1'b1, 4'd0);
      expect_beat(8'h11, 1'b1, 1'b0);
      expect_beat(8'h22, 1'b1, 1'b1);
      expect_beat(8'h11, 1'b1, 1'b0);
      expect_beat(8'h22, 1'b1, 1'b1);
      wait_drain("t2");

      // No interleave: req0 waits for the whole req1 packet
      push(1, 8'h30, 1'b0, 4'd0);
      push(1, 8'h31, 1'b0, 4'd0);
      push(1, 8'h32, 1'b1, 4'd0);
      push(0, 8'h55, 1'b1, 4'd1);
      expect_beat(8'h30, 1'b0, 1'b1);
      expect_beat(8'h31, 1'b0, 1'b1);
      expect_beat(8'h32, 1'b1, 1'b1);
      expect_beat(8'h55, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t3_ready0_low", {31'd0, rr[0]}, 32'd0);
      end
      @(negedge clk);
      chk("t3_ready0_grant", {31'd0, rr[0]}, 32'd1);
      wait_drain("t3");

      // Gap inside a req0 packet holds the grant
      push(0, 8'h01, 1'b0, 4'd0);
      push(0, 8'h02, 1'b1, 4'd3);
      push(1, 8'h99, 1'b1, 4'd1);
      expect_beat(8'h01, 1'b0, 1'b0);
      expect_beat(8'h02, 1'b1, 1'b0);
      expect_beat(8'h99, 1'b1, 1'b1);
      wait_drain("t4");

      // Backpressure: 4 stalled cycles, then drain and accept together
      out_ready = 1'b0;
      push(0, 8'h7E, 1'b0, 4'd0);
      push(0, 8'h7F, 1'b1, 4'd0);
      expect_beat(8'h7E, 1'b0, 1'b0);
      expect_beat(8'h7F, 1'b1, 1'b0);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 20);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         chk("t5_stall_data", {24'd0, out_data}, 32'h7E);
         chk("t5_stall_valid", {31'd0, out_valid}, 32'd1);
         chk("t5_stall_ready0", {31'd0, rr[0]}, 32'd0);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("t5_release_ready0", {31'd0, rr[0]}, 32'd1);
      wait_drain("t5");

      // Reset in the middle of a 4-beat packet
      push(0, 8'hC1, 1'b0, 4'd0);
      push(0, 8'hC2, 1'b0, 4'd0);
      push(0, 8'hC3, 1'b0, 4'd0);
      push(0, 8'hC4, 1'b1, 4'd0);
      expect_beat(8'hC1, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("t6_out_valid", {31'd0, out_valid}, 32'd0);
      chk("t6_out_data", {24'd0, out_data}, 32'd0);
      chk("t6_readies", {30'd0, rr}, 32'd0);
      push(0, 8'h44, 1'b1, 4'd0);
      push(1, 8'h88, 1'b1, 4'd0);
      expect_beat(8'h44, 1'b1, 1'b0);
      expect_beat(8'h88, 1'b1, 1'b1);
      wait_drain("t6");

      chk("sb_empty", sb.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks,
               errors);
      $finish;
   end

endmodule

// File: doc/mux2_8_arb.md
# mux2_8_arb

Packet-level arbiter that shares the 8-bit 2:1 datapath mux (`mux2_8`) between two requesters. It drives the mux select from a round-robin grant FSM that holds each grant for a whole packet, delimited by a `last` flag. Selected beats go through a single-entry registered output stage with valid/ready flow control. It sits between two producer channels and one consumer channel.

## Interface
- `WIDTH`, 8, data width of each beat (mux datapath width)
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `req0_valid`  in  1  requester 0 has a beat
- `req0_data`  in  WIDTH  requester 0 beat data
- `req0_last`  in  1  beat is final beat of requester 0 packet
- `req0_ready`  out  1  requester 0 beat accepted this cycle when high with `req0_valid`
- `req1_valid` / `req1_data` / `req1_last` / `req1_ready`: same as requester 0, for requester 1
- `out_valid`  out  1  output register holds a beat
- `out_data`  out  WIDTH  output beat data (mux output, registered)
- `out_last`  out  1  output beat is last of its packet
- `out_src`  out  1  requester index that produced the output beat
- `out_ready`  in  1  consumer accepts the output beat

## Operation
- FSM states: IDLE, GRANT0, GRANT1. A `prio` register holds the index of the last-served requester.
- IDLE:
  - Neither valid: stay in IDLE.
  - Exactly one valid: go to that requester's GRANTx.
  - Both valid: grant the requester != `prio`.
  - No beats are accepted in IDLE; both `reqN_ready` are 0.
- GRANTx:
  - Mux select = x.
  - `reqx_ready = !out_valid || out_ready`; the other requester's ready is 0.
  - On accept (`reqx_valid && reqx_ready`): load `out_data <= reqx_data`, `out_last <= reqx_last`, `out_src <= x`, `out_valid <= 1`.
  - Accept with `reqx_last = 1`: next state IDLE and `prio <= x`. Otherwise stay in GRANTx.
- Grant is held while the granted requester drops valid mid-packet; there is no timeout. The other requester waits.
- Output register:
  - `out_valid` clears when `out_ready && out_valid` and no new beat is accepted that cycle.
  - Simultaneous drain and accept keeps `out_valid = 1` with the new beat. No bubble.
  - While `out_valid && !out_ready`, all output fields hold stable.
- Valid/data/last of a non-granted requester are ignored and never reach the output.
- Reset values:
  - State IDLE, `prio = 1` (requester 0 wins the first tie).
  - `out_valid = 0`, `out_data = 0`, `out_last = 0`, `out_src = 0`.
  - `req0_ready = req1_ready = 0`.
- Reset mid-packet discards the partial packet and any held output beat.

## Timing
- All state and outputs are registered on the rising `clk` edge. `reqN_ready` is combinational from state, `out_valid` and `out_ready`.
- Arbitration latency: a valid first seen in IDLE at cycle n gives GRANTx at n+1. With the output empty or draining, `reqx_ready = 1` at n+1 and `out_valid = 1` at n+2.
- Sustained throughput inside a packet is 1 beat/cycle with `out_ready` held high.
- Each packet end costs one IDLE bubble cycle before the next grant.
- `out_ready` low for k cycles stalls the granted requester for exactly k cycles.

## Test plan
- Single requester: req0 sends 3 beats 0xA1, 0xA2, 0xA3 (last on 0xA3), `out_ready = 1` → `out_data` A1/A2/A3 on consecutive cycles starting 2 cycles after first valid, `out_src = 0`, `out_last` only on A3, then IDLE.
- Tie after reset: both valid, one-beat packets req0 = 0x11 and req1 = 0x22, held continuously → output order 0x11, 0x22, 0x11, 0x22, alternating `out_src`, one IDLE cycle between packets.
- No interleave: req1 mid-packet (0x30, 0x31, 0x32 last) while req0 asserts 0x55 → 0x55 appears only after 0x32 with `out_last = 1`. `req0_ready` stays 0 throughout.
- Backpressure: `out_ready = 0` for 4 cycles with 0x7E held → `out_data` stays 0x7E, `req0_ready = 0`. On release, the next beat is accepted the same cycle 0x7E drains.
- Gap in packet: req0 sends 0x01, drops valid 3 cycles, then 0x02 (last), req1 valid throughout → no req1 beat until after 0x02.
- Reset mid-packet: assert `reset` for 1 cycle after beat 2 of a 4-beat packet → next cycle `out_valid = 0`, both readies 0, state IDLE. A subsequent tie grants req0 first.
